bpr_line_sequencer: RTL
=======================

Name: bpr_line_sequencer

Overview:
- Sequences the bad-pixel-replacer averager over a raster pixel stream.
- Keeps a 3-pixel horizontal window (left, centre, right) per line and drives the averager with the left/right neighbours of the centre pixel.
- Substitutes the average only when the centre pixel is flagged bad; treats line edges as missing (bad) neighbours.
- Sits between the bad-pixel-flagging stage and the output stream; pixel word format is bit 14 = good flag, bits 13:0 = value.

Parameters:
- PIX_W, 15, pixel word width including the good flag in the MSB.
- CNT_W, 12, width of the per-line pixel counter and of cfg_width.

Ports:
- clk, input, 1, clock.
- srst, input, 1, synchronous active-high reset.
- cfg_width, input, CNT_W, expected pixels per line; sampled on the accepted SOF beat.
- s_tdata, input, PIX_W, input pixel.
- s_tvalid, input, 1, input valid.
- s_tready, output, 1, input ready.
- s_tuser, input, 1, start of frame on the first pixel.
- s_tlast, input, 1, end of line.
- m_tdata, output, PIX_W, output pixel.
- m_tvalid, output, 1, output valid.
- m_tready, input, 1, output ready.
- m_tuser, output, 1, SOF aligned to the output pixel.
- m_tlast, output, 1, EOL aligned to the output pixel.
- avg_cen, output, 1, averager clock enable.
- avg_pix_in_0, output, PIX_W, left neighbour to the averager.
- avg_pix_in_1, output, PIX_W, right neighbour to the averager.
- avg_pix_out, input, PIX_W, averager result; registered, valid 1 cycle after avg_cen.
- err_line_len, output, 1, sticky flag: a line length did not equal cfg_width.

Behaviour:
- Clock clk; reset srst, synchronous, active-high.
- Reset state:
  - FSM goes to IDLE; window registers are zeroed.
  - m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, avg_cen=0, err_line_len=0, s_tready=0 during reset.
  - Averager is reset by the same srst.
- Pipeline advance: adv = !m_tvalid_pipe_full || m_tready. Only two stages hold a pixel beyond the window: stage B (waiting on the averager) and the output register.
- s_tready = adv and state != FLUSH.
- Accept = s_tvalid and s_tready.
- FSM states:
  - IDLE: no pixel of the current line held. On accept, load C and enter HOLD1. L is treated as absent (value 0, flag 0). If s_tlast, go to FLUSH instead.
  - HOLD1: C held, L absent. On accept, R is the new pixel and C is emitted with left=absent, right=R; then L<=C, C<=new. Next state is RUN, or FLUSH if s_tlast.
  - RUN: L and C held. On accept, C is emitted with left=L, right=new; then shift L<=C, C<=new. Stay in RUN, or go to FLUSH if s_tlast.
  - FLUSH: no input accepted. When adv, C is emitted with left=L (absent if the line had only 1 pixel), right=absent, and m_tlast set. Next state is IDLE.
- Emit cycle:
  - avg_cen=1 and avg_pix_in_0/1 are driven combinationally from the window for that cycle only.
  - The centre pixel, its SOF flag (captured when the pixel was accepted) and its EOL flag are registered into stage B in the same cycle.
  - avg_cen=0 in all other cycles, and whenever adv=0.
- Stage B to output register, on adv:
  - If centre bit 14 = 1, m_tdata = centre unchanged.
  - Otherwise m_tdata = avg_pix_out. A pixel with both neighbours bad therefore goes out as 0 with flag 0.
  - The averager only advances with adv, so its result stays aligned with stage B under backpressure.
- Latency: an interior pixel appears at m_tdata 2 cycles after the accept of its right neighbour, with no stalls. The last pixel of a line appears 2 cycles after entering FLUSH.
- Throughput: 1 pixel per clock inside a line. There is one bubble per line (the FLUSH cycle).
- m_tvalid/m_tdata are held stable while m_tvalid=1 and m_tready=0.
- Line counter:
  - Reset to 1 on accepts in IDLE; incremented on accepts in HOLD1/RUN.
  - On the accept carrying s_tlast, if count != cfg_width, set err_line_len.
  - err_line_len clears only on srst.
- s_tuser arriving when the state is not IDLE: the partial line is flushed as if EOL had been seen, and err_line_len is set. The SOF pixel is held off (s_tready=0) until IDLE.
- srst mid-line discards all held pixels with no output. The first accept after srst is treated as a line start.

Test Plan:
- Line width 4, all good: values 10,20,30,40 -> output identical, m_tlast on 40, m_tuser on 10, err_line_len=0.
- Width 3, values good 100, bad, good 201 -> middle output {1,151} (0x4000|151); edges unchanged.
- Width 3, first pixel bad, second good 50, third good 70 -> first output = {1,50} (left neighbour absent); rest unchanged.
- Width 1, single bad pixel with tlast -> output 0x0000, m_tlast=1. Width 2, both bad -> two outputs 0x0000.
- Random m_tready backpressure on a 16-pixel line with random bad flags -> output matches a reference model bit-exact, no drops or duplicates, data stable while stalled.
- cfg_width=4 with a 3-pixel line, then srst asserted mid-line -> err_line_len=1 after tlast; after srst err_line_len=0, m_tvalid=0, and the next line is processed correctly from IDLE.

Source files
------------

// File: rtl/bpr_line_sequencer.sv
// Bad-pixel-replacer line sequencer: slides a 3-pixel window along each raster
//   line and feeds the left/right neighbours of the centre pixel to the averager.
// Ports: clk/srst; cfg_width (pixels per line, sampled on SOF); s_* input stream;
//   m_* output stream; avg_* averager handshake; err_line_len sticky length error.
// Latency 2 cycles from the right neighbour's accept; backpressure on m_tready
//   stalls the whole pipeline, including the averager through avg_cen.
module bpr_line_sequencer #(
  parameter int PIX_W = 15,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [PIX_W-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tuser,
  input  logic             s_tlast,
  output logic [PIX_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic             avg_cen,
  output logic [PIX_W-1:0] avg_pix_in_0,
  output logic [PIX_W-1:0] avg_pix_in_1,
  input  logic [PIX_W-1:0] avg_pix_out,
  output logic             err_line_len
);

  localparam int GOOD = PIX_W - 1;

  typedef enum logic [1:0] {IDLE, HOLD1, RUN, FLUSH} state_t;

  state_t           state;
  logic [PIX_W-1:0] l_pix, c_pix, b_pix;
  logic             l_vld, c_sof;
  logic             b_vld, b_sof, b_eol;
  logic [CNT_W-1:0] cnt, width_q;

  logic             adv, acc, emit, mid_line, sof_abort;
  logic [CNT_W-1:0] cnt_nxt, width_eff;

  assign adv      = !m_tvalid || m_tready;
  assign mid_line = (state == HOLD1) || (state == RUN);
  // An SOF inside a line closes the partial line; the SOF beat waits for IDLE.
  assign sof_abort = s_tvalid && s_tuser && mid_line;
  assign s_tready  = !srst && adv && (state != FLUSH) && !(s_tuser && mid_line);
  assign acc       = s_tvalid && s_tready;

  // A centre pixel leaves the window when its right neighbour arrives, or in
  // FLUSH when the line has ended and the right neighbour is absent.
  assign emit    = !srst && adv && ((acc && mid_line) || (state == FLUSH));
  assign avg_cen = emit;
  assign avg_pix_in_0 = (emit && l_vld) ? l_pix : '0;
  assign avg_pix_in_1 = (emit && state != FLUSH) ? s_tdata : '0;

  assign cnt_nxt   = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  // The SOF beat of a one-pixel line must compare against the width it carries.
  assign width_eff = s_tuser ? cfg_width : width_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= IDLE;
      l_pix        <= '0;
      c_pix        <= '0;
      l_vld        <= 1'b0;
      c_sof        <= 1'b0;
      b_vld        <= 1'b0;
      b_pix        <= '0;
      b_sof        <= 1'b0;
      b_eol        <= 1'b0;
      cnt          <= '0;
      width_q      <= '0;
      err_line_len <= 1'b0;
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      m_tuser      <= 1'b0;
      m_tlast      <= 1'b0;
    end else begin
      if (acc && s_tuser) width_q <= cfg_width;
      if ((acc && s_tlast && cnt_nxt != width_eff) || sof_abort)
        err_line_len <= 1'b1;

      case (state)
        IDLE: begin
          if (acc) begin
            c_pix <= s_tdata;
            c_sof <= s_tuser;
            l_vld <= 1'b0;
            cnt   <= cnt_nxt;
            state <= s_tlast ? FLUSH : HOLD1;
          end
        end
        HOLD1, RUN: begin
          if (acc) begin
            l_pix <= c_pix;
            l_vld <= 1'b1;
            c_pix <= s_tdata;
            c_sof <= s_tuser;
            cnt   <= cnt_nxt;
            state <= s_tlast ? FLUSH : RUN;
          end else if (sof_abort && adv) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (adv) begin
            l_vld <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Stage B and the output register move together so that the averager
      // result (one cycle behind avg_cen) always belongs to stage B.
      if (adv) begin
        b_vld    <= emit;
        b_pix    <= c_pix;
        b_sof    <= c_sof;
        b_eol    <= (state == FLUSH);
        m_tvalid <= b_vld;
        if (b_vld) begin
          m_tdata <= b_pix[GOOD] ? b_pix : avg_pix_out;
          m_tuser <= b_sof;
          m_tlast <= b_eol;
        end
      end
    end
  end

endmodule
